// File: rtl/tx_interface_pkg.sv
// Shared definitions for the UART calculator receive and transmit interfaces.
package tx_interface_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'd48;
    localparam logic [7:0] ASCII_LF   = 8'd10;

    // Common state encoding used by both the rx and tx interface FSMs
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CONV = 3'd1,
        LOAD = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    // Map a BCD digit onto its ASCII character
    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
        return ASCII_ZERO + {4'd0, digit};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one binary bit per cycle into three BCD digits.
// go loads the value; the following DBIT cycles each perform one add-3/shift step.
// done is high during the final shift cycle, so bcd holds the result from the next cycle on.
module bin2bcd_seq #(
    parameter int DBIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            go,
    input  logic [DBIT-1:0] bin,
    output logic            done,
    output logic [11:0]     bcd
);

    logic [DBIT-1:0] bin_reg;
    logic [3:0]      count;
    logic [10:0]     bcd_adj;

    // Add 3 to every digit that is 5 or more before it is doubled; the hundreds digit
    // can never exceed 2 before a shift for values up to 511, so it passes through
    always_comb begin
        bcd_adj = bcd[10:0];
        for (int i = 0; i < 2; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Load on go, then shift the adjusted digits left pulling in the next binary MSB
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_reg <= '0;
            bcd     <= '0;
            count   <= '0;
        end else if (go) begin
            bin_reg <= bin;
            bcd     <= '0;
            count   <= 4'(DBIT);
        end else if (count != 4'd0) begin
            bcd     <= {bcd_adj, bin_reg[DBIT-1]};
            bin_reg <= bin_reg << 1;
            count   <= count - 4'd1;
        end
    end

    assign done = (count == 4'd1);

endmodule

// File: rtl/tx_interface.sv
// Return path of the UART calculator: converts the ALU result to three ASCII decimal
// digits (plus optional terminator) and hands them to uart_tx one byte at a time.
module tx_interface
    import tx_interface_pkg::*;
#(
    parameter int         DBIT      = 8,
    parameter bit         SEND_TERM = 1'b1,
    parameter logic [7:0] TERM_CHAR = ASCII_LF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [DBIT-1:0] result,
    input  logic            tx_done_tick,
    output logic            tx_start,
    output logic [7:0]      din,
    output logic            busy,
    output logic            rd
);

    localparam logic [1:0] LAST_IDX = SEND_TERM ? 2'd3 : 2'd2;

    state_t      state, state_next;
    logic [1:0]  idx, idx_next;
    logic        conv_go;
    logic        conv_done;
    logic [11:0] bcd;

    assign conv_go = (state == IDLE) && start;

    bin2bcd_seq #(.DBIT(DBIT)) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .go    (conv_go),
        .bin   (result),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // State and character index registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= 2'd0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next-state logic: convert, then load/wait per character, then ack the parser
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    idx_next   = 2'd0;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (tx_done_tick) begin
                    if (idx == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx + 2'd1;
                        state_next = LOAD;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state register; din only carries a character
    // while a byte is being offered or transmitted
    always_comb begin
        tx_start = (state == LOAD);
        busy     = (state != IDLE);
        rd       = (state == DONE);
        din      = 8'd0;
        if (state == LOAD || state == WAIT) begin
            case (idx)
                2'd0:    din = digit_to_ascii(bcd[11:8]);
                2'd1:    din = digit_to_ascii(bcd[7:4]);
                2'd2:    din = digit_to_ascii(bcd[3:0]);
                default: din = TERM_CHAR;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_interface.sv
// Self-checking bench for tx_interface: a SEND_TERM=1 and a SEND_TERM=0 instance,
// table-driven frames plus directed restart, stray-tick and mid-frame reset sequences.
module tb_tx_interface;
    import tx_interface_pkg::*;

    localparam int DBIT = 8;

    typedef struct {
        int              sel;
        logic [DBIT-1:0] value;
        int              nbytes;
        logic [3:0][7:0] bytes;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      start;
    logic [1:0]      tick;
    logic [DBIT-1:0] result;
    logic [1:0]      tx_start;
    logic [1:0]      busy;
    logic [1:0]      rd;
    logic [7:0]      din0;
    logic [7:0]      din1;

    int n_cmp = 0;
    int n_fail = 0;
    int ts_cnt[2] = '{0, 0};
    int rd_cnt[2] = '{0, 0};

    tx_interface #(.DBIT(DBIT), .SEND_TERM(1'b1), .TERM_CHAR(8'd10)) dut_term (
        .clk          (clk),
        .reset        (reset),
        .start        (start[0]),
        .result       (result),
        .tx_done_tick (tick[0]),
        .tx_start     (tx_start[0]),
        .din          (din0),
        .busy         (busy[0]),
        .rd           (rd[0])
    );

    tx_interface #(.DBIT(DBIT), .SEND_TERM(1'b0), .TERM_CHAR(8'd10)) dut_noterm (
        .clk          (clk),
        .reset        (reset),
        .start        (start[1]),
        .result       (result),
        .tx_done_tick (tick[1]),
        .tx_start     (tx_start[1]),
        .din          (din1),
        .busy         (busy[1]),
        .rd           (rd[1])
    );

    always #5 clk = ~clk;

    // Count tx_start and rd pulses per instance as seen by a clocked consumer
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (tx_start[i]) ts_cnt[i]++;
            if (rd[i]) rd_cnt[i]++;
        end
    end

    // Watchdog so a stuck design can never hang the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] din_of(input int sel);
        return (sel != 0) ? din1 : din0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic wait_tx_start(input int sel, output logic seen, inout int cycles);
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (tx_start[sel]) begin
                seen = 1'b1;
                break;
            end
            step();
            cycles++;
        end
    endtask

    // mode 0: plain frame; 1: re-pulse start with a new result in the first WAIT;
    // 2: extra tick during the LOAD cycle of the second byte
    task automatic apply_stimulus(input int sel, input logic [DBIT-1:0] value, input int nbytes,
                                  input logic [3:0][7:0] bytes, input int mode);
        int   ts0;
        int   rd0;
        int   cycles;
        logic seen;
        ts0 = ts_cnt[sel];
        rd0 = rd_cnt[sel];
        result = value;
        start[sel] = 1'b1;
        step();
        start[sel] = 1'b0;
        cycles = 1;
        for (int b = 0; b < nbytes; b++) begin
            wait_tx_start(sel, seen, cycles);
            check_output($sformatf("tx_start byte%0d of %0d", b, value), 32'(seen), 32'd1);
            if (!seen) return;
            if (b == 0) check_output($sformatf("first tx_start latency %0d", value), 32'(cycles), 32'(DBIT + 1));
            check_output($sformatf("din byte%0d of %0d", b, value), 32'(din_of(sel)), 32'(bytes[3-b]));
            check_output("busy in frame", 32'(busy[sel]), 32'd1);
            if (mode == 2 && b == 1) begin
                tick[sel] = 1'b1;
                step();
                tick[sel] = 1'b0;
            end else begin
                step();
            end
            if (mode == 1 && b == 0) begin
                result = 8'd5;
                start[sel] = 1'b1;
                step();
                start[sel] = 1'b0;
            end
            repeat (18) step();
            check_output($sformatf("din held byte%0d of %0d", b, value), 32'(din_of(sel)), 32'(bytes[3-b]));
            tick[sel] = 1'b1;
            step();
            tick[sel] = 1'b0;
        end
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (rd[sel]) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check_output($sformatf("rd after frame %0d", value), 32'(seen), 32'd1);
        step();
        check_output("rd single pulse", 32'(rd[sel]), 32'd0);
        check_output("busy after frame", 32'(busy[sel]), 32'd0);
        repeat ((mode == 1) ? 40 : 3) step();
        check_output($sformatf("byte count %0d", value), 32'(ts_cnt[sel] - ts0), 32'(nbytes));
        check_output($sformatf("rd count %0d", value), 32'(rd_cnt[sel] - rd0), 32'd1);
        check_output("idle after frame", 32'(busy[sel]), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int   ts0;
        int   rd0;
        int   cycles;
        logic seen;

        vecs[0] = '{0, 8'd0,   4, {8'd48, 8'd48, 8'd48, 8'd10}};
        vecs[1] = '{0, 8'd255, 4, {8'd50, 8'd53, 8'd53, 8'd10}};
        vecs[2] = '{1, 8'd107, 3, {8'd49, 8'd48, 8'd55, 8'd0}};
        vecs[3] = '{0, 8'd9,   4, {8'd48, 8'd48, 8'd57, 8'd10}};
        vecs[4] = '{0, 8'd128, 4, {8'd49, 8'd50, 8'd56, 8'd10}};
        vecs[5] = '{1, 8'd64,  3, {8'd48, 8'd54, 8'd52, 8'd0}};

        reset  = 1'b0;
        start  = 2'b00;
        tick   = 2'b00;
        result = '0;
        repeat (3) step();
        check_output("reset tx_start", 32'(tx_start), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset rd", 32'(rd), 32'd0);
        check_output("reset din", 32'(din0), 32'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].sel, vecs[i].value, vecs[i].nbytes, vecs[i].bytes, 0);
        end

        // Stray tick while idle must not start anything
        ts0 = ts_cnt[0];
        tick[0] = 1'b1;
        step();
        tick[0] = 1'b0;
        repeat (3) step();
        check_output("stray tick idle busy", 32'(busy[0]), 32'd0);
        check_output("stray tick idle bytes", 32'(ts_cnt[0] - ts0), 32'd0);

        // Restart during WAIT is ignored; frame keeps 200
        apply_stimulus(0, 8'd200, 4, {8'd50, 8'd48, 8'd48, 8'd10}, 1);
        // Tick in the LOAD cycle is ignored; still four bytes
        apply_stimulus(0, 8'd31, 4, {8'd48, 8'd51, 8'd49, 8'd10}, 2);

        // Reset while waiting on the second byte aborts immediately without rd
        result = 8'd123;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        cycles = 1;
        wait_tx_start(0, seen, cycles);
        check_output("abort frame byte0", 32'(seen), 32'd1);
        step();
        tick[0] = 1'b1;
        step();
        tick[0] = 1'b0;
        wait_tx_start(0, seen, cycles);
        check_output("abort frame byte1", 32'(seen), 32'd1);
        check_output("abort frame din1", 32'(din0), 32'd50);
        repeat (4) step();
        rd0 = rd_cnt[0];
        reset = 1'b0;
        #1;
        check_output("abort tx_start", 32'(tx_start[0]), 32'd0);
        check_output("abort busy", 32'(busy[0]), 32'd0);
        check_output("abort rd", 32'(rd[0]), 32'd0);
        check_output("abort din", 32'(din0), 32'd0);
        repeat (3) step();
        reset = 1'b1;
        repeat (5) step();
        check_output("abort no rd pulse", 32'(rd_cnt[0] - rd0), 32'd0);
        check_output("abort stays idle", 32'(busy[0]), 32'd0);
        apply_stimulus(0, 8'd42, 4, {8'd48, 8'd52, 8'd50, 8'd10}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
